// File: rtl/lfsr_crc_check.sv
// rtl/lfsr_crc_check.sv - streaming receive-side CRC checker that strips the FCS and flags bad frames
//
// Optional feature macro: LFSR_CRC_CHECK_STATS_EN adds saturating frame counters
// (cnt_good, cnt_bad, cnt_runt) and a synchronous cnt_clear input.
//
// lfsr ports:
//   data_in   : data word folded into the CRC
//   state_in  : current LFSR state
//   state_out : LFSR state after data_in
//
// lfsr_crc_check ports:
//   clk, rst            : clock, asynchronous active-low reset
//   s_data/s_valid/s_ready/s_last : input frame (payload followed by FCS)
//   m_data/m_valid/m_ready/m_last : payload output, FCS stripped
//   m_crc_bad           : CRC mismatch, meaningful with m_valid & m_last
//   stat_good/bad/runt  : one-cycle frame result pulses

module lfsr #(
  parameter int                    LFSR_WIDTH        = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 32'h04c11db7,
  parameter string                 LFSR_CONFIG       = "GALOIS",
  parameter int                    LFSR_FEED_FORWARD = 0,
  parameter int                    REVERSE           = 1,
  parameter int                    DATA_WIDTH        = 8,
  parameter string                 STYLE             = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  // LSB-first operation shifts right, so it needs the bit-reflected polynomial.
  localparam logic [LFSR_WIDTH-1:0] POLY_REV = reflect(LFSR_POLY);

  if (LFSR_CONFIG != "GALOIS") begin : g_cfg_chk
    $error("lfsr: only the GALOIS configuration is implemented");
  end

  // Every style elaborates the same unrolled XOR network; only names are validated.
  if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_style_chk
    $error("lfsr: unknown STYLE");
  end

  logic [LFSR_WIDTH-1:0] st;
  logic                  fb;
  logic                  din;

  always_comb begin
    st  = state_in;
    fb  = 1'b0;
    din = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE != 0) begin
        din = data_in[i];
        fb  = st[0] ^ ((LFSR_FEED_FORWARD != 0) ? 1'b0 : din);
        st  = {1'b0, st[LFSR_WIDTH-1:1]} ^ (fb ? POLY_REV : '0);
        // Feed-forward mode injects data at the far end instead of the feedback path.
        if (LFSR_FEED_FORWARD != 0) st[LFSR_WIDTH-1] = st[LFSR_WIDTH-1] ^ din;
      end else begin
        din = data_in[DATA_WIDTH-1-i];
        fb  = st[LFSR_WIDTH-1] ^ ((LFSR_FEED_FORWARD != 0) ? 1'b0 : din);
        st  = {st[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
        if (LFSR_FEED_FORWARD != 0) st[0] = st[0] ^ din;
      end
    end
    state_out = st;
  end

endmodule

module lfsr_crc_check #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = '1,
  parameter string                 LFSR_CONFIG = "GALOIS",
  parameter int                    REVERSE     = 1,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [LFSR_WIDTH-1:0] RESIDUE     = 32'hdebb20e3,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  m_crc_bad,
  output logic                  stat_good,
  output logic                  stat_bad,
  output logic                  stat_runt
`ifdef LFSR_CRC_CHECK_STATS_EN
  ,
  input  logic                  cnt_clear,
  output logic [31:0]           cnt_good,
  output logic [31:0]           cnt_bad,
  output logic [31:0]           cnt_runt
`endif
);

  localparam int FCS_WORDS = LFSR_WIDTH / DATA_WIDTH;
  localparam int FILL_W    = $clog2(FCS_WORDS + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FCS_WORDS);

  logic [LFSR_WIDTH-1:0] state_q, state_d, crc_next;
  logic [FILL_W-1:0]     fill_q, fill_d;
  // FCS_WORDS-deep delay line; the output register is its final stage, so a
  // payload word leaves only once FCS_WORDS later words have arrived behind it.
  logic [DATA_WIDTH-1:0] dl_q [FCS_WORDS];
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  m_crc_bad_q, m_crc_bad_d;
  logic                  good_q, good_d, bad_q, bad_d, runt_q, runt_d;
  logic                  accept, full, crc_ok;

  lfsr #(
    .LFSR_WIDTH       (LFSR_WIDTH),
    .LFSR_POLY        (LFSR_POLY),
    .LFSR_CONFIG      (LFSR_CONFIG),
    .LFSR_FEED_FORWARD(0),
    .REVERSE          (REVERSE),
    .DATA_WIDTH       (DATA_WIDTH),
    .STYLE            (STYLE)
  ) u_lfsr (
    .data_in  (s_data),
    .state_in (state_q),
    .state_out(crc_next)
  );

  assign s_ready = !m_valid_q | m_ready;
  assign accept  = s_valid & s_ready;
  assign full    = (fill_q == FILL_MAX);
  assign crc_ok  = (crc_next == RESIDUE);

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_crc_bad_d = m_crc_bad_q;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    runt_d      = 1'b0;
    if (m_ready) m_valid_d = 1'b0;
    if (accept) begin
      if (full) begin
        m_valid_d   = 1'b1;
        m_data_d    = dl_q[FCS_WORDS-1];
        m_last_d    = s_last;
        m_crc_bad_d = s_last & !crc_ok;
      end
      if (s_last) begin
        state_d = LFSR_INIT;
        fill_d  = '0;
        good_d  = full & crc_ok;
        bad_d   = full & !crc_ok;
        runt_d  = !full;
      end else begin
        state_d = crc_next;
        if (!full) fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LFSR_INIT;
      fill_q      <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_crc_bad_q <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      runt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_crc_bad_q <= m_crc_bad_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      runt_q      <= runt_d;
    end
  end

  // Delay line contents are don't-care after reset; the fill count gates their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      dl_q[0] <= s_data;
      for (int i = 1; i < FCS_WORDS; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_crc_bad = m_crc_bad_q;
  assign stat_good = good_q;
  assign stat_bad  = bad_q;
  assign stat_runt = runt_q;

`ifdef LFSR_CRC_CHECK_STATS_EN
  logic [31:0] cnt_good_q, cnt_bad_q, cnt_runt_q;

  // Clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_good_q <= '0;
      cnt_bad_q  <= '0;
      cnt_runt_q <= '0;
    end else if (cnt_clear) begin
      cnt_good_q <= '0;
      cnt_bad_q  <= '0;
      cnt_runt_q <= '0;
    end else begin
      if (good_q && cnt_good_q != '1) cnt_good_q <= cnt_good_q + 32'd1;
      if (bad_q && cnt_bad_q != '1)   cnt_bad_q  <= cnt_bad_q + 32'd1;
      if (runt_q && cnt_runt_q != '1) cnt_runt_q <= cnt_runt_q + 32'd1;
    end
  end

  assign cnt_good = cnt_good_q;
  assign cnt_bad  = cnt_bad_q;
  assign cnt_runt = cnt_runt_q;
`endif

endmodule
